// File: rtl/nes_controller_reader.sv
// -----------------------------------------------------------------------------
// nes_controller_reader
//
// Serial NES gamepad front end. On a start pulse it raises the controller
// latch, waits one half-period, samples bit 0 (A), then issues seven
// nes_clk pulses and samples one bit at the end of each low half. The
// active-low serial bits are inverted and published on buttons with a
// one-cycle valid strobe.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   read request pulse, honoured only when idle
//   nes_data   in   controller serial data, active-low, asynchronous
//   nes_latch  out  controller latch, registered, active-high
//   nes_clk    out  controller shift clock, registered, idles low
//   buttons    out  pressed buttons, active-high
//                   (bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right)
//   valid      out  one-cycle strobe, coincident with a buttons update
//   busy       out  high whenever a read is in progress
// -----------------------------------------------------------------------------
module nes_controller_reader #(
    parameter int LATCH_CYCLES = 300,  // latch pulse width, 2..65535
    parameter int HALF_CYCLES  = 150   // nes_clk half-period, 4..65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        BIT0_WAIT,
        CLK_HIGH,
        CLK_LOW,
        DONE
    } state_t;

    // Counter reload values: a state loaded with N-1 lasts exactly N cycles.
    localparam logic [15:0] LATCH_LOAD = 16'(LATCH_CYCLES - 1);
    localparam logic [15:0] HALF_LOAD  = 16'(HALF_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [1:0]  r_sync;
    logic        r_nes_latch;
    logic        r_nes_clk;
    logic [7:0]  r_buttons;
    logic        r_valid;
    logic        r_busy;

    logic        w_data_s;
    logic        w_cnt_zero;

    assign w_data_s   = r_sync[1];
    assign w_cnt_zero = (r_cnt == 16'd0);

    // Two-flop synchronizer. Resets to 1, the released (no button) level.
    // NOTE: sequential blocks use non-blocking assignments so every flop
    // samples pre-edge values, whatever order the statements appear in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], nes_data};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment first guarantees a value on every path,
    // so no latch is inferred even where a branch leaves the state alone.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:      if (start)      w_next_state = LATCH;
            LATCH:     if (w_cnt_zero) w_next_state = BIT0_WAIT;
            BIT0_WAIT: if (w_cnt_zero) w_next_state = CLK_HIGH;
            CLK_HIGH:  if (w_cnt_zero) w_next_state = CLK_LOW;
            CLK_LOW: begin
                if (w_cnt_zero) begin
                    w_next_state = (r_bit_idx == 3'd7) ? DONE : CLK_HIGH;
                end
            end
            DONE:      w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // Dwell counter: reloaded on every state change, otherwise counts to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (w_next_state != r_state) begin
            r_cnt <= (w_next_state == LATCH) ? LATCH_LOAD : HALF_LOAD;
        end else if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    // Bit capture. Bit 0 is taken at the end of the post-latch wait, bits
    // 1..7 on the last cycle of each nes_clk low half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= 8'h00;
            r_bit_idx <= 3'd0;
        end else if (w_cnt_zero) begin
            if (r_state == BIT0_WAIT) begin
                r_shift[0] <= ~w_data_s;
                r_bit_idx  <= 3'd1;
            end else if (r_state == CLK_LOW) begin
                r_shift[r_bit_idx] <= ~w_data_s;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end
        end
    end

    // Outputs. Pin and busy flops are loaded from the next state so they
    // switch on the same edge as the state itself.
    // NOTE: decoding the pins straight from the multi-bit state register
    // could glitch on a transition; a flop per pin cannot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nes_latch <= 1'b0;
            r_nes_clk   <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_buttons   <= 8'h00;
        end else begin
            r_nes_latch <= (w_next_state == LATCH);
            r_nes_clk   <= (w_next_state == CLK_HIGH);
            r_busy      <= (w_next_state != IDLE);
            r_valid     <= (r_state == DONE);
            if (r_state == DONE) begin
                r_buttons <= r_shift;
            end
        end
    end

    assign nes_latch = r_nes_latch;
    assign nes_clk   = r_nes_clk;
    assign buttons   = r_buttons;
    assign valid     = r_valid;
    assign busy      = r_busy;

endmodule
